// File: rtl/ks10_bus_arbiter.sv
// KS10 backplane bus arbiter.
// Grants the shared bus round-robin among NREQ masters (index 0 = CPU),
// issues a one-cycle request strobe and waits for the slave acknowledge or a
// timeout. It then returns read data and a done/NXM pulse to the owner.
module ks10_bus_arbiter #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 63,
  parameter int CPUPARK = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      reqI,
  input  logic [NREQ*36-1:0]   addrI,
  input  logic [NREQ*36-1:0]   dataI,
  output logic                 busREQO,
  output logic [35:0]          busADDRO,
  output logic [35:0]          busDATAO,
  input  logic                 busACKI,
  input  logic [35:0]          busDATAI,
  output logic [NREQ-1:0]      gntO,
  output logic [NREQ-1:0]      doneO,
  output logic [NREQ-1:0]      nxmO,
  output logic [35:0]          dataO,
  output logic                 busyO
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [NREQ-1:0] PARK_GNT = (CPUPARK != 0) ? NREQ'(1) : '0;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_e;

  state_e          state_q, state_d;
  logic [NREQ-1:0] gnt_q;
  logic [IW-1:0]   last_q;
  logic [35:0]     addr_q, wdata_q, rdata_q;
  logic [7:0]      cnt_q;
  logic            nxm_q;

  // Round-robin winner, searching upward from last_q+1 and wrapping to 0.
  logic            found;
  logic [IW-1:0]   win_idx;
  logic [NREQ-1:0] win_gnt;
  logic [35:0]     win_addr, win_data;

  // Arbitration: first pass above the last winner, second pass wraps around.
  always_comb begin
    // NOTE: every comb output gets a default first so no latch is inferred.
    found    = 1'b0;
    win_idx  = last_q;
    win_gnt  = '0;
    win_addr = '0;
    win_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!found && reqI[i] && (i > int'(last_q))) begin
        found    = 1'b1;
        win_idx  = IW'(i);
        win_gnt  = NREQ'(1) << i;
        win_addr = addrI[36*i +: 36];
        win_data = dataI[36*i +: 36];
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!found && reqI[i]) begin
        found    = 1'b1;
        win_idx  = IW'(i);
        win_gnt  = NREQ'(1) << i;
        win_addr = addrI[36*i +: 36];
        win_data = dataI[36*i +: 36];
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic: a timeout fires when the counter would step to zero.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (|reqI) state_d = REQ;
      REQ:     state_d = busACKI ? DONE : WAIT;
      WAIT:    if (busACKI || (cnt_q <= 8'd1)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from state; done/nxm go only to the owner.
  always_comb begin
    busREQO = (state_q == REQ);
    busyO   = (state_q != IDLE);
    doneO   = (state_q == DONE) ? gnt_q : '0;
    nxmO    = ((state_q == DONE) && nxm_q) ? gnt_q : '0;
  end

  // Datapath: grant/address latch in IDLE, timeout count and read capture.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gnt_q   <= PARK_GNT;
      last_q  <= IW'(NREQ - 1);
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
      nxm_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (found) begin
            gnt_q   <= win_gnt;
            addr_q  <= win_addr;
            wdata_q <= win_data;
            last_q  <= win_idx;
          end else if (CPUPARK != 0) begin
            // Parked on the CPU: keep its request word on the bus mux.
            gnt_q   <= PARK_GNT;
            addr_q  <= addrI[35:0];
            wdata_q <= dataI[35:0];
          end else begin
            gnt_q   <= '0;
          end
        end
        REQ: begin
          cnt_q <= 8'(TIMEOUT);
          nxm_q <= 1'b0;
          if (busACKI) rdata_q <= busDATAI;
        end
        WAIT: begin
          if (busACKI) begin
            rdata_q <= busDATAI;
            nxm_q   <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 8'd1;
            if (cnt_q <= 8'd1) begin
              rdata_q <= '0;
              nxm_q   <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign gntO     = gnt_q;
  assign busADDRO = addr_q;
  assign busDATAO = wdata_q;
  assign dataO    = rdata_q;

endmodule

// File: tb/tb_ks10_bus_arbiter.sv
// Bench for ks10_bus_arbiter: directed stimulus pushes expected strobes and
// completions into queues; a monitor pops and compares on every DUT event.
module tb_ks10_bus_arbiter;

  localparam int NREQ    = 4;
  localparam int TIMEOUT = 63;
  localparam int CPUPARK = 1;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic [NREQ-1:0]      reqI = '0;
  logic [NREQ*36-1:0]   addrI = '0;
  logic [NREQ*36-1:0]   dataI = '0;
  logic                 busREQO;
  logic [35:0]          busADDRO, busDATAO;
  logic                 busACKI = 1'b0;
  logic [35:0]          busDATAI = '0;
  logic [NREQ-1:0]      gntO, doneO, nxmO;
  logic [35:0]          dataO;
  logic                 busyO;

  ks10_bus_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT), .CPUPARK(CPUPARK)) dut (
    .clk(clk), .rst(rst), .reqI(reqI), .addrI(addrI), .dataI(dataI),
    .busREQO(busREQO), .busADDRO(busADDRO), .busDATAO(busDATAO),
    .busACKI(busACKI), .busDATAI(busDATAI), .gntO(gntO), .doneO(doneO),
    .nxmO(nxmO), .dataO(dataO), .busyO(busyO)
  );

  always #5 clk = ~clk;

  typedef struct { logic [35:0] addr; logic [35:0] wdata; logic [3:0] gnt; } req_t;
  typedef struct { logic [3:0] owner; logic nxm; logic [35:0] rdata; int lat; } done_t;

  req_t  exp_req[$];
  done_t exp_done[$];
  req_t  r_item;
  done_t d_item;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_req_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: compares each strobe and each completion against the queues.
  always @(negedge clk) begin
    if (rst) begin
      if (busREQO) begin
        last_req_cyc = cyc;
        if (exp_req.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_strobe: gnt %0h addr %0h", gntO, busADDRO);
        end else begin
          r_item = exp_req.pop_front();
          check("strobe_gnt",  gntO,     r_item.gnt);
          check("strobe_addr", busADDRO, r_item.addr);
          check("strobe_data", busDATAO, r_item.wdata);
        end
      end
      if (|doneO) begin
        if (exp_done.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done: done %0h nxm %0h", doneO, nxmO);
        end else begin
          d_item = exp_done.pop_front();
          check("done_owner",   doneO, d_item.owner);
          check("done_nxm",     nxmO,  d_item.nxm ? d_item.owner : 4'b0);
          check("done_rdata",   dataO, d_item.rdata);
          check("done_latency", cyc - last_req_cyc, d_item.lat);
        end
      end else if (|nxmO) begin
        check("nxm_without_done", nxmO, 4'b0);
      end
    end
  end

  task automatic wait_req(input string tag, output int c);
    c = -1;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (busREQO) begin
        c = cyc;
        return;
      end
    end
    checks++; errors++;
    $display("FAIL %s: no busREQO within 200 cycles", tag);
  endtask

  task automatic wait_done(input string tag, output int c);
    c = -1;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (|doneO) begin
        c = cyc;
        return;
      end
    end
    checks++; errors++;
    $display("FAIL %s: no doneO within 200 cycles", tag);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic ack_now(input logic [35:0] rd);
    busACKI  = 1'b1;
    busDATAI = rd;
    @(posedge clk);
    #1 busACKI = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_gnt"},   gntO,     4'b0001);
    check({tag, "_req"},   busREQO,  1'b0);
    check({tag, "_done"},  doneO,    4'b0);
    check({tag, "_nxm"},   nxmO,     4'b0);
    check({tag, "_busy"},  busyO,    1'b0);
    check({tag, "_dataO"}, dataO,    36'b0);
    check({tag, "_addr"},  busADDRO, 36'b0);
    check({tag, "_wdata"}, busDATAO, 36'b0);
  endtask

  initial begin
    if (TIMEOUT < 1 || TIMEOUT > 255) begin
      $display("FAIL timeout_param: TIMEOUT=%0d outside 1..255", TIMEOUT);
      $fatal(1, "illegal TIMEOUT");
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s, d, prev;
    logic [35:0] rd4;

    // Reset state.
    #12;
    check_reset_values("reset");
    @(negedge clk);
    rst = 1'b1;

    // Single CPU read, ack three cycles after the strobe.
    addrI[35:0] = 36'o000100_001234;
    dataI[35:0] = 36'o000000_000777;
    exp_req.push_back('{36'o000100_001234, 36'o000000_000777, 4'b0001});
    exp_done.push_back('{4'b0001, 1'b0, 36'o123456_654321, 4});
    reqI = 4'b0001;
    wait_req("cpu_read", s);
    repeat (3) @(posedge clk);
    #1;
    ack_now(36'o123456_654321);
    reqI = 4'b0000;
    repeat (3) @(negedge clk);

    // All four masters continuously, ack in REQ: order 0,1,2,3,0,1,2,3.
    do_reset();
    for (int i = 0; i < NREQ; i++) begin
      addrI[36*i +: 36] = 36'h1_0000_0000 + 36'(i);
      dataI[36*i +: 36] = 36'h2_0000_0000 + 36'(i);
    end
    for (int k = 0; k < 8; k++)
      exp_req.push_back('{36'h1_0000_0000 + 36'(k % 4), 36'h2_0000_0000 + 36'(k % 4),
                          4'(1 << (k % 4))});
    reqI = 4'b1111;
    prev = 0;
    for (int k = 0; k < 8; k++) begin
      wait_req("round_robin", s);
      if (k > 0) check("rr_spacing", s - prev, 3);
      prev = s;
      exp_done.push_back('{4'(1 << (k % 4)), 1'b0, 36'h3_0000_0000 + 36'(k), 1});
      ack_now(36'h3_0000_0000 + 36'(k));
      if (k == 7) reqI = 4'b0000;
    end
    repeat (3) @(negedge clk);

    // No ack on master 0: NXM after 64 cycles, then master 2 is granted.
    exp_req.push_back('{36'h1_0000_0000, 36'h2_0000_0000, 4'b0001});
    exp_req.push_back('{36'h1_0000_0002, 36'h2_0000_0002, 4'b0100});
    exp_done.push_back('{4'b0001, 1'b1, 36'b0, 64});
    reqI = 4'b0101;
    wait_req("timeout", s);
    wait_done("timeout", d);
    check("timeout_cycles", d - s, 64);
    reqI = 4'b0100;
    exp_done.push_back('{4'b0100, 1'b0, 36'h4_5555_0001, 1});
    wait_req("after_timeout", s);
    check("next_grant_cycle", s - d, 2);
    ack_now(36'h4_5555_0001);
    reqI = 4'b0000;
    repeat (3) @(negedge clk);

    // Master 2 drops reqI and changes addrI while in WAIT.
    addrI[72 +: 36] = 36'o222222_000002;
    dataI[72 +: 36] = 36'o333333_000002;
    exp_req.push_back('{36'o222222_000002, 36'o333333_000002, 4'b0100});
    reqI = 4'b0100;
    wait_req("drop_req", s);
    @(posedge clk);
    @(posedge clk);
    #1;
    reqI = 4'b0000;
    addrI[72 +: 36] = 36'o777777_777777;
    dataI[72 +: 36] = 36'o666666_666666;
    @(negedge clk);
    check("hold_addr", busADDRO, 36'o222222_000002);
    check("hold_data", busDATAO, 36'o333333_000002);
    check("hold_gnt",  gntO,     4'b0100);
    check("hold_busy", busyO,    1'b1);
    rd4 = 36'o101010_202020;
    exp_done.push_back('{4'b0100, 1'b0, rd4, 5});
    @(posedge clk);
    @(posedge clk);
    #1;
    ack_now(rd4);
    repeat (4) @(negedge clk);

    // Spurious ack while idle and parked.
    check("park_gnt",  gntO,  4'b0001);
    check("park_busy", busyO, 1'b0);
    @(posedge clk);
    #1;
    busACKI  = 1'b1;
    busDATAI = 36'o765432_123456;
    repeat (3) @(posedge clk);
    #1 busACKI = 1'b0;
    @(negedge clk);
    check("spurious_dataO", dataO, rd4);
    check("spurious_busy",  busyO, 1'b0);
    check("spurious_gnt",   gntO,  4'b0001);
    addrI[35:0] = 36'o000200_004321;
    @(negedge clk);
    check("park_addr_follow", busADDRO, 36'o000200_004321);

    // Reset during WAIT with master 1 granted, then re-arbitration.
    addrI[36 +: 36] = 36'o111111_000001;
    dataI[36 +: 36] = 36'o444444_000001;
    exp_req.push_back('{36'o111111_000001, 36'o444444_000001, 4'b0010});
    reqI = 4'b0010;
    wait_req("reset_mid", s);
    @(posedge clk);
    @(posedge clk);
    #1;
    check("pre_reset_busy", busyO, 1'b1);
    check("pre_reset_gnt",  gntO,  4'b0010);
    rst = 1'b0;
    #1;
    check_reset_values("mid_reset");
    @(negedge clk);
    @(negedge clk);
    exp_req.push_back('{36'o111111_000001, 36'o444444_000001, 4'b0010});
    exp_done.push_back('{4'b0010, 1'b0, 36'o050505_060606, 1});
    rst = 1'b1;
    wait_req("after_reset", s);
    ack_now(36'o050505_060606);
    reqI = 4'b0000;
    repeat (4) @(negedge clk);

    check("exp_req_drained",  exp_req.size(),  0);
    check("exp_done_drained", exp_done.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ks10_bus_arbiter.md
Name: ks10_bus_arbiter

Overview:
Arbitrates the KS10 backplane bus between up to NREQ masters: CPU, console interface, and UBA DMA engines. Grants the bus round-robin and drives the selected master's address/data onto the bus for a one-cycle request strobe. Waits for the slave acknowledge, or a timeout, then returns read data and a completion or NXM indication to the owning master. The block sits between the masters and the shared bus, replacing the per-master NXM/ioWAIT timers.

Parameters:
NREQ, 4, number of bus masters; index 0 = CPU.
TIMEOUT, 63, cycles to wait for busACKI before declaring non-existent memory/device (1..255).
CPUPARK, 1, 1 = bus parks on master 0 when idle (grant to 0 costs no arbitration cycle).

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-low
reqI  in  NREQ  per-master request level; held until that master's doneO
addrI  in  NREQ*36  per-master address+flags word, slice i = bits [36*i +: 36]
dataI  in  NREQ*36  per-master write data, same slicing
busREQO  out  1  bus request strobe, one cycle per transaction
busADDRO  out  36  address+flags of granted master
busDATAO  out  36  write data of granted master
busACKI  in  1  slave acknowledge
busDATAI  in  36  read data from slave, valid with busACKI
gntO  out  NREQ  one-hot grant, owner of current transaction
doneO  out  NREQ  one-cycle completion pulse to owner
nxmO  out  NREQ  one-cycle timeout pulse to owner, coincident with doneO
dataO  out  36  latched read data, valid when doneO is high
busyO  out  1  transaction in progress (state != IDLE)

Behaviour:
- Reset (rst low, asynchronous): state IDLE; gntO = 1 if CPUPARK else 0; busREQO, doneO, nxmO, busyO = 0; dataO = 0; busADDRO/busDATAO = 0; last-grant pointer = NREQ-1; timeout counter = 0.
- States: IDLE -> REQ -> WAIT -> DONE -> IDLE.
- IDLE: if any reqI is set, select a winner by round-robin, searching from last+1 modulo NREQ. Register the one-hot gntO, the winner's addrI/dataI into busADDRO/busDATAO, and update last. Go to REQ.
- REQ: busREQO = 1 for exactly this cycle; load counter = TIMEOUT; go to WAIT. busACKI sampled in REQ is also accepted: go directly to DONE, capturing busDATAI.
- WAIT: on busACKI, capture busDATAI into dataO and go to DONE with nxm = 0. Otherwise decrement the counter. When the counter reaches 0 without an ack, set dataO = 0 and go to DONE with nxm = 1.
- DONE: doneO[owner] = 1 and nxmO[owner] = nxm for one cycle; go to IDLE. The owner must drop or renew reqI by the next cycle. A request still high in IDLE is treated as a new transaction.
- Grant latency: request seen in IDLE at cycle N -> busREQO at N+1 -> earliest doneO at N+2 (ack in REQ cycle).
- busADDRO/busDATAO/gntO are held stable from REQ through DONE. Changes to addrI/dataI during a transaction are ignored.
- Parking (CPUPARK=1): in IDLE with no requests, gntO = 1 and busADDRO follows addrI slice 0, but busREQO stays 0. A parked CPU request still goes through REQ (no cycle saving on the strobe, only on the mux).
- Simultaneous requests: exactly one winner per arbitration. A master requesting continuously gets at most one transaction per NREQ while others wait (no starvation).
- Spurious busACKI in IDLE or DONE: ignored; no state change, dataO unchanged.
- Requester dropping reqI mid-transaction: the transaction still completes and doneO still pulses.
- reqI bits at index >= NREQ: not present. TIMEOUT = 0 is illegal; the bench asserts on it.
- Reset mid-transaction: immediate return to reset values; no doneO pulse is emitted.

Test Plan:
- Single CPU read: reqI=0001, addrI[0]=36'o000100_001234, ack 3 cycles after busREQO with busDATAI=36'o123456_654321 -> one busREQO pulse carrying that address; doneO=0001 one cycle after the ack; dataO=36'o123456654321; nxmO=0.
- All four masters request continuously, with ack in the REQ cycle -> grant order 0,1,2,3,0,...; each transaction takes 3 cycles; no master is granted twice within any window of 4 grants.
- No ack, TIMEOUT=63 -> doneO and nxmO pulse for the owner exactly 64 cycles after busREQO; dataO=0; the next requester is granted in the following IDLE.
- Master 2 drops reqI and changes addrI in WAIT -> busADDRO stays at the latched value; doneO[2] still pulses once.
- Spurious busACKI while IDLE with no requests -> no doneO; dataO unchanged; gntO=0001 (parked).
- rst low during WAIT with master 1 granted -> outputs return to reset values immediately, with no doneO. After release, reqI=0010 still high -> re-arbitrated and completed normally.
